// File: rtl/gt_sweep_checker_pkg.sv
// Shared types and defaults for the greater-than comparator sweep checker.
package gt_sweep_checker_pkg;

    localparam int GT_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/gt_vector_counter.sv
// Test-vector counter: {a,b} packed as one 2*WIDTH-bit index, b in the low half.
module gt_vector_counter
    import gt_sweep_checker_pkg::*;
#(
    parameter int WIDTH = GT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clr,
    input  logic                 en,
    output logic [2*WIDTH-1:0]   vec,
    output logic                 last
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vec <= '0;
        end else if (clr) begin
            vec <= '0;
        end else if (en) begin
            vec <= vec + (2*WIDTH)'(1);
        end
    end

    // All-ones index is (max,max); the controller stops there so the count never wraps.
    assign last = &vec;

endmodule

// File: rtl/gt_sweep_checker.sv
// Exhaustively sweeps an external unsigned greater-than comparator and tallies mismatches.
module gt_sweep_checker
    import gt_sweep_checker_pkg::*;
#(
    parameter int WIDTH = GT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 gt_in,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   first_fail
);

    sweep_state_t             state, state_nxt;
    logic [2*WIDTH-1:0]       vec;
    logic                     vec_last;
    logic                     cnt_clr;
    logic                     cnt_en;
    logic                     stats_clr;
    logic                     err_inc;
    logic                     ff_load;
    logic                     golden;
    logic                     mismatch;

    gt_vector_counter #(
        .WIDTH (WIDTH)
    ) u_vector_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .vec   (vec),
        .last  (vec_last)
    );

    assign a_out    = vec[2*WIDTH-1:WIDTH];
    assign b_out    = vec[WIDTH-1:0];
    assign golden   = (a_out > b_out);
    assign mismatch = (gt_in != golden);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        stats_clr = 1'b0;
        err_inc   = 1'b0;
        ff_load   = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    stats_clr = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_nxt = abort ? ST_IDLE : ST_SAMPLE;
            end
            ST_SAMPLE: begin
                // Abort wins: the vector in flight is neither counted nor advanced.
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    err_inc = mismatch;
                    ff_load = mismatch && (err_count == '0);
                    if (vec_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_en    = 1'b1;
                        state_nxt = ST_DRIVE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_count  <= '0;
            first_fail <= '0;
        end else if (stats_clr) begin
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            if (err_inc) begin
                err_count <= err_count + (2*WIDTH+1)'(1);
            end
            if (ff_load) begin
                first_fail <= vec;
            end
        end
    end

    assign busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: doc/gt_sweep_checker.md
GT_SWEEP_CHECKER -- requirements
Module: gt_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width of the comparator under check.
REQ-002 SHALL have clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have n_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have start  input  1  single-cycle pulse that begins a sweep.
REQ-005 SHALL have abort  input  1  terminates a running sweep.
REQ-006 SHALL have gt_in  input  1  greater-than result returned by the external comparator.
REQ-007 SHALL have a_out  output  WIDTH  registered operand A driven to the comparator.
REQ-008 SHALL have b_out  output  WIDTH  registered operand B driven to the comparator.
REQ-009 SHALL have busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have done  output  1  high once a sweep has completed, until the next start.
REQ-011 SHALL have pass  output  1  valid when done is high; 1 if no mismatches.
REQ-012 SHALL have err_count  output  2*WIDTH+1  number of mismatching vectors.
REQ-013 SHALL have first_fail  output  2*WIDTH  {a,b} of the first mismatch; zero if none.

Function
REQ-014 SHALL implement states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL: clear err_count, first_fail and done; load a_out=b_out=0; go to DRIVE.
REQ-016 start SHALL be ignored in DRIVE and SAMPLE.
REQ-017 DRIVE SHALL hold a_out/b_out stable for one cycle so the combinational comparator settles, then go to SAMPLE.
REQ-018 SAMPLE SHALL compare gt_in against the golden result (a_out > b_out, unsigned).
REQ-019 On mismatch with err_count==0, SAMPLE SHALL capture {a_out,b_out} into first_fail.
REQ-020 On any mismatch, SAMPLE SHALL increment err_count by 1; no saturation (max 2^(2*WIDTH) fits).
REQ-021 After SAMPLE, the vector SHALL advance with b as the inner index and a as the outer index: (0,0),(0,1)..(0,max),(1,0)..(max,max).
REQ-022 After SAMPLE of (max,max), the block SHALL go to DONE instead of advancing; operands SHALL not wrap.
REQ-023 Each vector SHALL take exactly 2 cycles; done SHALL rise 2*2^(2*WIDTH) cycles after the start edge (512 for WIDTH=4).
REQ-024 busy SHALL be 1 in DRIVE and SAMPLE only; done SHALL be 1 in DONE only.
REQ-025 pass SHALL equal done AND (err_count==0).
REQ-026 abort=1 in DRIVE or SAMPLE SHALL return to IDLE next cycle with done=0; counters hold their values.
REQ-027 abort SHALL have priority over the SAMPLE result in the same cycle (that vector is not counted).
REQ-028 abort in IDLE or DONE SHALL have no effect; start and abort together in IDLE SHALL start the sweep.

Reset
REQ-029 n_rst low SHALL immediately force state IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-030 Reset asserted mid-sweep SHALL discard all progress; a subsequent start SHALL run a full sweep.

Structure
REQ-031 A shared package SHALL hold the state enum type and the default WIDTH constant.
REQ-032 The vector counter SHALL be a sub-module gt_vector_counter (2*WIDTH-bit, clear/enable, last-vector flag).
REQ-033 The external comparator SHALL not be instantiated inside this block.

Verification
REQ-034 Ideal comparator model on gt_in, start pulse -> done=1 at cycle 512, pass=1, err_count=0, first_fail=0.
REQ-035 gt_in tied 0 -> err_count=120, first_fail={4'd1,4'd0}, pass=0.
REQ-036 gt_in = inverted ideal -> err_count=256, first_fail={4'd0,4'd0}.
REQ-037 Second start pulse at cycle 100 -> ignored, done still at cycle 512 relative to the first start.
REQ-038 abort at cycle 50 -> busy=0 and state IDLE at cycle 51, done=0; new start runs a full clean sweep.
REQ-039 n_rst pulsed low at cycle 300 -> all outputs 0 asynchronously; restart yields pass=1 with ideal model.
